// File: rtl/uart_tx_responder_if.sv
// uart_tx_responder_if: core data-bus link between a master and the UART TX responder.
//   iReadEnable/iWriteEnable : bus strobes
//   iByteEnable              : write byte lanes
//   iAddress/iWriteData      : byte address and write data
//   oReadData                : responder read data, 0 when not selected
interface uart_tx_responder_if;
  logic        iReadEnable;
  logic        iWriteEnable;
  logic [3:0]  iByteEnable;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic [31:0] oReadData;
  modport master (output iReadEnable, iWriteEnable, iByteEnable, iAddress, iWriteData, input oReadData);
  modport slave (input iReadEnable, iWriteEnable, iByteEnable, iAddress, iWriteData, output oReadData);
endinterface

// File: rtl/uart_tx_responder.sv
// uart_tx_responder: memory-mapped 8N1 UART transmitter with TX FIFO on the core data bus.
//   iCLK, iRST : clock, asynchronous active-high reset
//   bus        : slave side of uart_tx_responder_if (combinational reads, posedge writes)
//   oTx        : registered serial line, idle high
//   oIrq       : only with UART_TX_IRQ_EN defined; registered "drained and idle" interrupt
// Registers: 0x0 TXDATA, 0x4 STATUS, 0x8 DIVISOR, 0xC IRQCTRL (UART_TX_IRQ_EN) or reserved.
module uart_tx_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hFF200100,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic iCLK,
  input  logic iRST,
  uart_tx_responder_if.slave bus,
`ifdef UART_TX_IRQ_EN
  output logic oIrq,
`endif
  output logic oTx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wp_q, rp_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ov_q, ov_d;
  logic [15:0]     div_q, bit_div_q, tick_q;
  logic [7:0]      shift_q;
  logic [2:0]      bit_q;
  logic            tx_q;
  logic            sel, wr, full, empty, busy, pop, push_req, push_ok, ov_clr, bit_end, irq_s;
  logic [1:0]      off;
  logic [31:0]     status, irqctrl;
  logic            unused_bits;
  assign unused_bits = ^{bus.iWriteData[31:16], bus.iAddress[1:0]};
  always_comb begin
    sel      = bus.iAddress[31:4] == BASE_ADDR[31:4];
    off      = bus.iAddress[3:2];
    wr       = sel && bus.iWriteEnable;
    full     = cnt_q == CW'(FIFO_DEPTH);
    empty    = cnt_q == '0;
    busy     = state_q != IDLE;
    pop      = !busy && !empty;
    push_req = wr && off == 2'd0 && bus.iByteEnable[0];
    // a pop in the same cycle frees the slot, so a push to a full FIFO still fits
    push_ok  = push_req && (!full || pop);
    cnt_d    = cnt_q + CW'(push_ok) - CW'(pop);
    ov_clr   = wr && off == 2'd1 && bus.iByteEnable[0] && bus.iWriteData[3];
    ov_d     = (push_req && !push_ok) || (ov_q && !ov_clr);
    bit_end  = tick_q == bit_div_q;
    status   = {16'h0, 8'(cnt_q), 3'b0, irq_s, ov_q, busy, empty, full};
    bus.oReadData = !(sel && bus.iReadEnable) ? 32'h0 :
                    off == 2'd1 ? status :
                    off == 2'd2 ? {16'h0, div_q} :
                    off == 2'd3 ? irqctrl : 32'h0;
  end
`ifdef UART_TX_IRQ_EN
  logic irq_en_q;
  assign irq_s   = oIrq;
  assign irqctrl = {31'h0, irq_en_q};
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      irq_en_q <= 1'b0;
      oIrq     <= 1'b0;
    end else begin
      if (wr && off == 2'd3 && bus.iByteEnable[0]) irq_en_q <= bus.iWriteData[0];
      oIrq <= irq_en_q && empty && !busy;
    end
`else
  assign irq_s   = 1'b0;
  assign irqctrl = 32'h0;
`endif
  always_ff @(posedge iCLK)
    if (push_ok) mem_q[wp_q] <= bus.iWriteData[7:0];
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ov_q  <= 1'b0;
      div_q <= DEFAULT_DIV;
    end else begin
      if (push_ok) wp_q <= wp_q + PW'(1);
      if (pop) rp_q <= rp_q + PW'(1);
      cnt_q <= cnt_d;
      ov_q  <= ov_d;
      if (wr && off == 2'd2 && bus.iByteEnable[1:0] == 2'b11) div_q <= bus.iWriteData[15:0];
    end
  // tx_q is loaded with the level of the state being entered, keeping oTx a pure flop output
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_div_q <= '0;
      tick_q    <= '0;
      bit_q     <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (pop) begin
            shift_q   <= mem_q[rp_q];
            bit_div_q <= div_q;
            tick_q    <= '0;
            bit_q     <= '0;
            tx_q      <= 1'b0;
            state_q   <= START;
          end else tx_q <= 1'b1;
        START:
          if (bit_end) begin
            tick_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else tick_q <= tick_q + 16'd1;
        DATA:
          if (bit_end) begin
            tick_q  <= '0;
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 3'd1;
            tx_q    <= bit_q == 3'd7 ? 1'b1 : shift_q[1];
            state_q <= bit_q == 3'd7 ? STOP : DATA;
          end else tick_q <= tick_q + 16'd1;
        STOP:
          if (bit_end) begin
            tick_q  <= '0;
            state_q <= IDLE;
          end else tick_q <= tick_q + 16'd1;
        default: state_q <= IDLE;
      endcase
    end
  assign oTx = tx_q;
endmodule

// File: tb/tb_uart_tx_responder.sv
// tb_uart_tx_responder: directed self-checking bench for uart_tx_responder.
module tb_uart_tx_responder;
  localparam logic [31:0] BASE = 32'hFF200100;
  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        oTx;
`ifdef UART_TX_IRQ_EN
  logic        oIrq;
`endif
  int          n_pass = 0;
  int          n_chk = 0;
  logic [31:0] d;
  logic [9:0]  fr;
  uart_tx_responder_if bus();
  uart_tx_responder dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus(bus.slave),
`ifdef UART_TX_IRQ_EN
    .oIrq(oIrq),
`endif
    .oTx(oTx)
  );
  always #5 iCLK = ~iCLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.iAddress = a;
    bus.iReadEnable = 1'b1;
    #1 v = bus.oReadData;
    bus.iReadEnable = 1'b0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] be);
    bus.iAddress = a;
    bus.iWriteData = v;
    bus.iByteEnable = be;
    bus.iWriteEnable = 1'b1;
    @(posedge iCLK);
    #1 bus.iWriteEnable = 1'b0;
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask
  initial begin
    bus.iReadEnable = 1'b0;
    bus.iWriteEnable = 1'b0;
    bus.iByteEnable = 4'h0;
    bus.iAddress = 32'h0;
    bus.iWriteData = 32'h0;
    #12 iRST = 1'b0;
    tick(1);
    rd(BASE + 4, d);  check("rst_status", d, 32'h2);
    rd(BASE + 8, d);  check("rst_div", d, 32'd433);
    check("rst_tx", {31'h0, oTx}, 32'h1);
    rd(32'h1000_0000, d); check("nosel_read", d, 32'h0);
    rd(BASE, d);      check("txdata_read", d, 32'h0);
    rd(BASE + 12, d); check("reserved_read", d, 32'h0);
    wr(BASE + 8, 32'd3, 4'hF);
    rd(BASE + 8, d);  check("div_write", d, 32'd3);
    // A5 frame at 4 cycles/bit: start 0, data LSB first, stop 1
    wr(BASE, 32'hA5, 4'h1);
    check("pre_frame_tx", {31'h0, oTx}, 32'h1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      tick(1);
      check($sformatf("a5_bit%0d", i), {31'h0, oTx}, {31'h0, fr[i/4]});
      if (i == 0 || i == 39) begin
        rd(BASE + 4, d);
        check($sformatf("a5_busy%0d", i), {31'h0, d[2]}, 32'h1);
      end
    end
    tick(1);
    rd(BASE + 4, d);  check("a5_done_status", d, 32'h2);
    check("a5_done_tx", {31'h0, oTx}, 32'h1);
    wr(BASE, 32'h55, 4'b0010);
    rd(BASE + 4, d);  check("be_txdata", d, 32'h2);
    wr(BASE + 8, 32'h1234, 4'b0001);
    rd(BASE + 8, d);  check("be_div", d, 32'd3);
    // DIVISOR=0: frames take 11 cycles, so 2 pops land among 17 back-to-back writes
    wr(BASE + 8, 32'd0, 4'hF);
    for (int k = 0; k < 17; k++) wr(BASE, k, 4'h1);
    rd(BASE + 4, d);  check("burst17_status", d, 32'h0000_0F04);
    wr(BASE, 32'h11, 4'h1);
    rd(BASE + 4, d);  check("full_status", d, 32'h0000_1005);
    wr(BASE, 32'h12, 4'h1);
    rd(BASE + 4, d);  check("overflow_status", d, 32'h0000_100D);
    wr(BASE + 4, 32'h8, 4'h1);
    rd(BASE + 4, d);  check("ov_clear_status", d, 32'h0000_1005);
    for (int i = 0; i < 400 && d !== 32'h2; i++) begin
      tick(1);
      rd(BASE + 4, d);
    end
    check("drain_status", d, 32'h2);
    // reset mid-frame while a zero data bit is on the line
    wr(BASE + 8, 32'd3, 4'hF);
    for (int k = 0; k < 3; k++) wr(BASE, 32'h00, 4'h1);
    tick(6);
    check("mid_data_tx", {31'h0, oTx}, 32'h0);
    #2 iRST = 1'b1;
    #1 check("async_rst_tx", {31'h0, oTx}, 32'h1);
    rd(BASE + 4, d);  check("in_rst_status", d, 32'h2);
    #2 iRST = 1'b0;
    tick(1);
    rd(BASE + 4, d);  check("post_rst_status", d, 32'h2);
    rd(BASE + 8, d);  check("post_rst_div", d, 32'd433);
    check("post_rst_tx", {31'h0, oTx}, 32'h1);
`ifdef UART_TX_IRQ_EN
    check("irq_rst", {31'h0, oIrq}, 32'h0);
    wr(BASE + 8, 32'd3, 4'hF);
    wr(BASE + 12, 32'h1, 4'hF);
    rd(BASE + 12, d); check("irqctrl_read", d, 32'h1);
    check("irq_lag", {31'h0, oIrq}, 32'h0);
    tick(1);
    check("irq_on", {31'h0, oIrq}, 32'h1);
    rd(BASE + 4, d);  check("irq_status", d, 32'h12);
    wr(BASE, 32'h3C, 4'h1);
    tick(1);
    check("irq_busy", {31'h0, oIrq}, 32'h0);
    tick(40);
    check("irq_frame_end", {31'h0, oIrq}, 32'h0);
    tick(1);
    check("irq_back", {31'h0, oIrq}, 32'h1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
